fp8_encoder: RTL and testbench

Converts a signed 34-bit fixed-point accumulator value back into the team's 8-bit minifloat format: sign bit [7], exponent [6:3], mantissa [2:0]. The decoded magnitude of a code is {n, mantissa} << (exponent − n), where n = (exponent != 0). The block is the write-back end of the TPU MAC path: it takes a finished accumulation and produces an fp8 operand that can feed the next layer's MAC inputs. It accepts values through a valid/ready handshake, normalizes serially one bit per cycle, rounds, and holds the result until the consumer takes it.

---
 rtl/fp8_pkg.sv | 25 ++
 rtl/fp8_round_pack.sv | 69 ++++++
 rtl/fp8_encoder.sv | 107 ++++++++++
 tb/tb_fp8_encoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// fp8_pkg: field layout, limits and FSM encoding shared by the fp8 encoder.
// Rev 1.0
`default_nettype none

package fp8_pkg;
  localparam int ACC_W    = 34;
  localparam int SHIFT    = 3;
  localparam int LZ_W     = 6;
  localparam int SIGN_BIT = 7;
  localparam int EXP_MSB  = 6;
  localparam int EXP_LSB  = 3;
  localparam int MAN_MSB  = 2;
  localparam int MAN_LSB  = 0;
  localparam int EXP_MAX  = 15;
  localparam logic [6:0] SAT_CODE = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2,
    OUT  = 2'd3
  } state_t;
endpackage

`default_nettype wire

// File: rtl/fp8_round_pack.sv
// fp8_round_pack: rounds a left-normalized magnitude (RNE) and packs the fp8 code.
// Rev 1.0
`default_nettype none

module fp8_round_pack
  import fp8_pkg::*;
(
  input  logic [ACC_W-1:0] i_mag,
  input  logic [LZ_W-1:0]  i_lz,
  input  logic             i_sign,
  output logic [7:0]       o_code,
  output logic             o_sat
);
  // Exponent of a normal result is E_TOP - lz; lz >= E_TOP means subnormal.
  localparam int E_TOP = ACC_W - 3 - SHIFT;
  localparam int LOW_W = SHIFT + 3;

  logic [LOW_W-1:0] w_low;
  logic [5:0]       w_e;
  logic [4:0]       w_kept;
  logic [4:0]       w_rnd;
  logic             w_guard;
  logic             w_sticky;
  logic             w_inc;

  // Subnormals need original-coordinate bits, so undo the normalization shift.
  assign w_low = LOW_W'(i_mag >> i_lz);

  always_comb begin
    w_e      = '0;
    w_kept   = '0;
    w_guard  = 1'b0;
    w_sticky = 1'b0;
    w_inc    = 1'b0;
    w_rnd    = '0;
    o_code   = '0;
    o_sat    = 1'b0;
    if (i_lz < LZ_W'(E_TOP)) begin
      w_e      = 6'(E_TOP) - 6'(i_lz);
      w_kept   = {1'b0, i_mag[ACC_W-1 -: 4]};
      w_guard  = i_mag[ACC_W-5];
      w_sticky = |i_mag[ACC_W-6:0];
    end else begin
      w_kept   = {2'b00, w_low[SHIFT+2:SHIFT]};
      w_guard  = w_low[SHIFT-1];
      w_sticky = |w_low[SHIFT-2:0];
    end
    w_inc = w_guard & (w_sticky | w_kept[0]);
    w_rnd = w_kept + {4'b0000, w_inc};
    if (w_e != 6'd0 && w_rnd[4]) begin
      w_e   = w_e + 6'd1;
      w_rnd = 5'd8;
    end else if (w_e == 6'd0 && w_rnd[3]) begin
      w_e = 6'd1;
    end
    if (i_mag == '0 || (w_e == 6'd0 && w_rnd == 5'd0)) begin
      o_code = 8'h00;
    end else if (w_e > 6'(EXP_MAX)) begin
      o_code = {i_sign, SAT_CODE};
      o_sat  = 1'b1;
    end else begin
      o_code[SIGN_BIT]        = i_sign;
      o_code[EXP_MSB:EXP_LSB] = w_e[3:0];
      o_code[MAN_MSB:MAN_LSB] = w_rnd[2:0];
    end
  end
endmodule

`default_nettype wire

// File: rtl/fp8_encoder.sv
// fp8_encoder: serial-normalizing accumulator-to-fp8 converter with valid/ready on both sides.
// Rev 1.0
`default_nettype none

module fp8_encoder
  import fp8_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [ACC_W-1:0] i_acc_in,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [7:0]       o_fp8_out,
  output logic             o_sat
);
  state_t           r_state, w_state_nxt;
  logic [ACC_W-1:0] r_mag, w_mag_nxt;
  logic [LZ_W-1:0]  r_lz, w_lz_nxt;
  logic             r_sign, w_sign_nxt;
  logic [7:0]       r_fp8, w_fp8_nxt;
  logic             r_sat, w_sat_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic [ACC_W-1:0] w_abs;
  logic [7:0]       w_code;
  logic             w_code_sat;

  // -2^(ACC_W-1) negates to itself, which reads correctly as an unsigned magnitude.
  assign w_abs = i_acc_in[ACC_W-1] ? -i_acc_in : i_acc_in;

  fp8_round_pack u_round_pack (
    .i_mag  (r_mag),
    .i_lz   (r_lz),
    .i_sign (r_sign),
    .o_code (w_code),
    .o_sat  (w_code_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mag       <= '0;
      r_lz        <= '0;
      r_sign      <= 1'b0;
      r_fp8       <= 8'h00;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mag       <= w_mag_nxt;
      r_lz        <= w_lz_nxt;
      r_sign      <= w_sign_nxt;
      r_fp8       <= w_fp8_nxt;
      r_sat       <= w_sat_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mag_nxt       = r_mag;
    w_lz_nxt        = r_lz;
    w_sign_nxt      = r_sign;
    w_fp8_nxt       = r_fp8;
    w_sat_nxt       = r_sat;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      IDLE: begin
        if (i_in_valid) begin
          w_sign_nxt  = i_acc_in[ACC_W-1];
          w_mag_nxt   = w_abs;
          w_lz_nxt    = '0;
          w_state_nxt = NORM;
        end
      end
      NORM: begin
        if (!r_mag[ACC_W-1] && r_mag != '0) begin
          w_mag_nxt = {r_mag[ACC_W-2:0], 1'b0};
          w_lz_nxt  = r_lz + LZ_W'(1);
        end else begin
          w_state_nxt = PACK;
        end
      end
      PACK: begin
        w_fp8_nxt       = w_code;
        w_sat_nxt       = w_code_sat;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = OUT;
      end
      OUT: begin
        if (i_out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_in_ready  = (r_state == IDLE);
  assign o_out_valid = r_out_valid;
  assign o_fp8_out   = r_fp8;
  assign o_sat       = r_sat;
endmodule

`default_nettype wire

// File: tb/tb_fp8_encoder.sv
// tb_fp8_encoder: directed scoreboard bench for fp8_encoder.
// Rev 1.0
`default_nettype none

module tb_fp8_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_in_valid = 1'b0;
  logic        o_in_ready;
  logic [33:0] i_acc_in = '0;
  logic        o_out_valid;
  logic        i_out_ready = 1'b0;
  logic [7:0]  o_fp8_out;
  logic        o_sat;

  typedef struct {
    logic [7:0] code;
    logic       sat;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  fp8_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_acc_in    (i_acc_in),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_fp8_out   (o_fp8_out),
    .o_sat       (o_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one value through the accept edge and queue its expected result.
  task automatic accept(input logic [33:0] acc, input logic [7:0] c, input logic s, input int lat);
    exp_t e;
    @(negedge clk);
    chk("in_ready_idle", 32'(o_in_ready), 32'd1);
    i_acc_in   = acc;
    i_in_valid = 1'b1;
    e.code = c; e.sat = s; e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_acc_in   = 34'($urandom);
  endtask

  task automatic collect();
    int   k;
    exp_t e;
    k = 0;
    do begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end while (!o_out_valid && k < 50);
    e = sb.pop_front();
    chk("code", 32'(o_fp8_out), 32'(e.code));
    chk("sat", 32'(o_sat), 32'(e.sat));
    chk("latency", 32'(k), 32'(e.lat));
  endtask

  task automatic ack();
    i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    i_out_ready = 1'b0;
    chk("valid_clr", 32'(o_out_valid), 32'd0);
  endtask

  task automatic xfer(input logic [33:0] acc, input logic [7:0] c, input logic s, input int lat);
    accept(acc, c, s, lat);
    collect();
    ack();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(o_in_ready), 32'd1);
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_fp8", 32'(o_fp8_out), 32'h00);
    chk("rst_sat", 32'(o_sat), 32'd0);
    rst_n = 1'b1;

    xfer(34'd0,             8'h00, 1'b0, 2);
    xfer(34'd64,            8'h08, 1'b0, 29);
    xfer(-34'd40,           8'h85, 1'b0, 30);
    xfer(34'd136,           8'h10, 1'b0, 28);
    xfer(34'd152,           8'h12, 1'b0, 28);
    xfer(34'd1966080,       8'h7F, 1'b0, 15);
    xfer(34'h1_FFFF_FFFF,   8'h7F, 1'b1, 3);
    xfer(34'h2_0000_0000,   8'hFF, 1'b1, 2);
    xfer(-34'd5,            8'h81, 1'b0, 33);
    xfer(-34'd4,            8'h00, 1'b0, 33);
    xfer(34'd1,             8'h00, 1'b0, 35);
    xfer(34'd60,            8'h08, 1'b0, 30);
    xfer(34'd248,           8'h18, 1'b0, 28);
    xfer(34'd2031616,       8'h7F, 1'b1, 15);

    // Backpressure: result held while a new value waits on the input.
    accept(34'd152, 8'h12, 1'b0, 28);
    collect();
    i_in_valid = 1'b1;
    i_acc_in   = 34'd64;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(o_out_valid), 32'd1);
      chk("bp_code", 32'(o_fp8_out), 32'h12);
      chk("bp_in_ready", 32'(o_in_ready), 32'd0);
    end
    ack();
    accept(34'd64, 8'h08, 1'b0, 29);
    collect();
    ack();

    // Asynchronous reset in the middle of normalization.
    @(negedge clk);
    i_acc_in   = 34'd64;
    i_in_valid = 1'b1;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("norm_in_ready", 32'(o_in_ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(o_out_valid), 32'd0);
    chk("arst_in_ready", 32'(o_in_ready), 32'd1);
    chk("arst_fp8", 32'(o_fp8_out), 32'h00);
    chk("arst_sat", 32'(o_sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    xfer(-34'd40, 8'h85, 1'b0, 30);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
